// File: rtl/sram_fifo_pkg.sv
// Shared types and widths for the SRAM FIFO sequencer.
package sram_fifo_pkg;

  localparam int unsigned FIFO_DATA_W  = 32;
  localparam int unsigned FIFO_AVAIL_W = 22;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRise,
    StWaitFall
  } arb_state_e;

endpackage

// File: rtl/sram_fifo_arbiter_if.sv
// Producer, consumer and SRAM FIFO command/status signals of the sequencer.
// master: the sequencer's view; slave: the surrounding environment's view.
interface sram_fifo_arbiter_if;
  import sram_fifo_pkg::*;

  // Producer side
  logic                    wr_valid;
  logic [FIFO_DATA_W-1:0]  wr_data;
  logic                    wr_ready;
  // Consumer side
  logic                    rd_req;
  logic [FIFO_DATA_W-1:0]  rd_data;
  logic                    rd_valid;
  logic                    rd_empty;
  logic                    rd_pending;
  // SRAM FIFO side
  logic [FIFO_DATA_W-1:0]  fifo_din;
  logic                    fifo_we;
  logic                    fifo_re;
  logic [FIFO_DATA_W-1:0]  fifo_dout;
  logic                    fifo_rdy;
  logic                    fifo_busy;
  logic                    fifo_full;
  logic [FIFO_AVAIL_W-1:0] fifo_avail;

  modport master (
    input  wr_valid, wr_data, rd_req,
    input  fifo_dout, fifo_rdy, fifo_busy, fifo_full, fifo_avail,
    output wr_ready, rd_data, rd_valid, rd_empty, rd_pending,
    output fifo_din, fifo_we, fifo_re
  );

  modport slave (
    output wr_valid, wr_data, rd_req,
    output fifo_dout, fifo_rdy, fifo_busy, fifo_full, fifo_avail,
    input  wr_ready, rd_data, rd_valid, rd_empty, rd_pending,
    input  fifo_din, fifo_we, fifo_re
  );

endinterface

// File: rtl/stage_fifo.sv
// Small register FIFO used to stage producer words. Depth must be a power
// of two so the pointers wrap naturally.
module stage_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign head    = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sram_fifo_arbiter.sv
// Sequencer in front of the single-port SRAM FIFO: stages producer words and
// turns writes and consumer reads into one-cycle fifo_we/fifo_re commands,
// each waiting for the SRAM FIFO busy cycle to complete.
// Optional statistics counters: define SRAM_FIFO_ARB_STATS_EN.
module sram_fifo_arbiter
  import sram_fifo_pkg::*;
#(
  parameter int unsigned STAGE_DEPTH = 4,
  parameter int unsigned BUSY_TMO    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_fifo_arbiter_if.master    bus,
  output logic                   err,
  output logic [FIFO_DATA_W-1:0] wr_cnt,
  output logic [FIFO_DATA_W-1:0] rd_cnt
);

  localparam int unsigned TmoW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TMO - 1);

  arb_state_e             state_q, state_d;
  logic                   wr_go_q, wr_go_d, rd_go_q, rd_go_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic                   err_q, err_d;
  logic                   rd_pending_q, rd_pending_d;
  logic [FIFO_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_empty_q, rd_empty_d;

  logic                   stage_empty, stage_full, stage_pop;
  logic [FIFO_DATA_W-1:0] stage_head;
  logic                   wr_go, rd_go;
  logic                   issue_we, issue_re;
  logic [FIFO_DATA_W-1:0] issue_din;

  stage_fifo #(
    .Depth (STAGE_DEPTH),
    .Width (FIFO_DATA_W)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.wr_valid),
    .push_data (bus.wr_data),
    .pop       (stage_pop),
    .head      (stage_head),
    .empty     (stage_empty),
    .full      (stage_full)
  );

  assign stage_pop = (state_q == StIssue) && wr_go_q;
  assign wr_go     = !stage_empty && !bus.fifo_full;
  // A read may ride along with a write even when the SRAM FIFO is empty.
  assign rd_go     = rd_pending_q && ((bus.fifo_avail != '0) || wr_go);

  // Next-state, command and consumer-response logic.
  always_comb begin
    state_d      = state_q;
    wr_go_d      = wr_go_q;
    rd_go_d      = rd_go_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    rd_pending_d = rd_pending_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_empty_d   = 1'b0;
    issue_we     = 1'b0;
    issue_re     = 1'b0;
    issue_din    = '0;

    if (bus.rd_req && !rd_pending_q) rd_pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (wr_go || rd_go) begin
          wr_go_d = wr_go;
          rd_go_d = rd_go;
          state_d = StIssue;
        end else if (rd_pending_q) begin
          // Nothing to read and nothing about to be written: drop the read.
          rd_empty_d   = 1'b1;
          rd_pending_d = 1'b0;
        end
      end
      StIssue: begin
        issue_we = wr_go_q;
        issue_re = rd_go_q;
        if (wr_go_q) issue_din = stage_head;
        tmo_d   = '0;
        state_d = StWaitRise;
      end
      StWaitRise: begin
        if (bus.fifo_busy) begin
          state_d = StWaitFall;
        end else if (tmo_q == TmoLast) begin
          // Command was never acknowledged; report it and move on.
          err_d = 1'b1;
          if (rd_go_q) rd_pending_d = 1'b0;
          rd_go_d = 1'b0;
          wr_go_d = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitFall: begin
        // rd_go_q doubles as "read data still expected".
        if (rd_go_q && bus.fifo_rdy) begin
          rd_data_d    = bus.fifo_dout;
          rd_valid_d   = 1'b1;
          rd_pending_d = 1'b0;
          rd_go_d      = 1'b0;
        end
        if (!bus.fifo_busy) begin
          if (rd_go_q && !bus.fifo_rdy) rd_pending_d = 1'b0;
          rd_go_d = 1'b0;
          wr_go_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_go_q      <= 1'b0;
      rd_go_q      <= 1'b0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_empty_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_go_q      <= wr_go_d;
      rd_go_q      <= rd_go_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      rd_pending_q <= rd_pending_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_empty_q   <= rd_empty_d;
    end
  end

  assign bus.wr_ready   = !stage_full;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_empty   = rd_empty_q;
  assign bus.rd_pending = rd_pending_q;
  assign bus.fifo_we    = issue_we;
  assign bus.fifo_re    = issue_re;
  assign bus.fifo_din   = issue_din;
  assign err            = err_q;

`ifdef SRAM_FIFO_ARB_STATS_EN
  logic [FIFO_DATA_W-1:0] wr_cnt_q, rd_cnt_q;

  // Free-running command/result counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (issue_we)   wr_cnt_q <= wr_cnt_q + FIFO_DATA_W'(1);
      if (rd_valid_q) rd_cnt_q <= rd_cnt_q + FIFO_DATA_W'(1);
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`else
  assign wr_cnt = '0;
  assign rd_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Directed bench for sram_fifo_arbiter with a simple SRAM FIFO responder.
module tb_sram_fifo_arbiter;

  logic        clk;
  logic        rst_n;
  logic        err;
  logic [31:0] wr_cnt, rd_cnt;

  sram_fifo_arbiter_if bus ();

  sram_fifo_arbiter #(
    .STAGE_DEPTH (4),
    .BUSY_TMO    (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .err    (err),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
  );

`ifdef SRAM_FIFO_ARB_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          model_on = 1'b1;
  logic [31:0] model_rdata = 32'h0;
  int          we_cnt = 0, re_cnt = 0, both_cnt = 0, rv_cnt = 0, pulse_viol = 0;
  logic [31:0] din_q[$];
  logic        prev_we = 1'b0, prev_re = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // Observe command and response pulses on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.fifo_we) begin
        we_cnt++;
        din_q.push_back(bus.fifo_din);
      end
      if (bus.fifo_re) re_cnt++;
      if (bus.fifo_we && bus.fifo_re) both_cnt++;
      if (bus.rd_valid) rv_cnt++;
      if ((bus.fifo_we && prev_we) || (bus.fifo_re && prev_re)) pulse_viol++;
      prev_we = bus.fifo_we;
      prev_re = bus.fifo_re;
    end
  end

  // SRAM FIFO responder: busy one cycle after a command, rdy on the 4th busy
  // cycle for reads, busy drops two cycles after that.
  initial begin
    logic m_rd;
    bus.fifo_busy = 1'b0;
    bus.fifo_rdy  = 1'b0;
    bus.fifo_dout = '0;
    forever begin
      @(negedge clk);
      if (model_on && (bus.fifo_we || bus.fifo_re)) begin
        m_rd = bus.fifo_re;
        @(posedge clk); #1 bus.fifo_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (m_rd) begin
          bus.fifo_rdy  = 1'b1;
          bus.fifo_dout = model_rdata;
        end
        @(posedge clk); #1;
        bus.fifo_rdy  = 1'b0;
        bus.fifo_dout = '0;
        @(posedge clk); #1 bus.fifo_busy = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
    bus.fifo_full = 1'b0; bus.fifo_avail = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready);
    end
    n_checks++;
    if ({bus.rd_valid, bus.rd_empty, bus.rd_pending, bus.fifo_we, bus.fifo_re, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.rd_valid, bus.rd_empty, bus.rd_pending, bus.fifo_we, bus.fifo_re, err});
    end
    n_checks++;
    if ({bus.rd_data, bus.fifo_din, wr_cnt, rd_cnt} !== 128'b0) begin
      n_fail++; $display("FAIL reset_words: got %h want 0", {bus.rd_data, bus.fifo_din, wr_cnt, rd_cnt});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_write();
    int we0;
    we0 = we_cnt;
    #1; bus.wr_valid = 1'b1; bus.wr_data = 32'hDEADBEEF;
    @(posedge clk); #1 bus.wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.fifo_we !== 1'b0) begin
      n_fail++; $display("FAIL write_early: fifo_we got %b want 0 one cycle after accept", bus.fifo_we);
    end
    @(negedge clk);
    n_checks++;
    if (bus.fifo_we !== 1'b1 || bus.fifo_din !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_issue: we/din got %b/%h want 1/deadbeef", bus.fifo_we, bus.fifo_din);
    end
    repeat (12) @(posedge clk);
    n_checks++;
    if (we_cnt - we0 !== 1) begin
      n_fail++; $display("FAIL write_count: fifo_we pulses got %0d want 1", we_cnt - we0);
    end
    n_checks++;
    if (wr_cnt !== (StatsEn ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL write_wr_cnt: got %0d want %0d", wr_cnt, StatsEn ? 1 : 0);
    end
  endtask

  task automatic test_single_read();
    int re0, rv0;
    bit found;
    re0 = re_cnt; rv0 = rv_cnt; found = 0;
    bus.fifo_avail = 22'd3; model_rdata = 32'h12345678;
    #1 bus.rd_req = 1'b1;
    @(posedge clk); #1 bus.rd_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rd_pending !== 1'b1) begin
      n_fail++; $display("FAIL read_pending_set: got %b want 1", bus.rd_pending);
    end
    // Second request while pending must be ignored.
    @(posedge clk); #1 bus.rd_req = 1'b1;
    @(posedge clk); #1 bus.rd_req = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.rd_valid) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL read_valid: rd_valid seen got 0 want 1 within 30 cycles");
    end
    n_checks++;
    if (bus.rd_data !== 32'h12345678 || bus.rd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data: data/pending got %h/%b want 12345678/0", bus.rd_data, bus.rd_pending);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_valid_width: got %b want 0 on second cycle", bus.rd_valid);
    end
    repeat (12) @(posedge clk);
    n_checks++;
    if (re_cnt - re0 !== 1 || rv_cnt - rv0 !== 1) begin
      n_fail++; $display("FAIL read_counts: re/valid got %0d/%0d want 1/1", re_cnt - re0, rv_cnt - rv0);
    end
    n_checks++;
    if (rd_cnt !== (StatsEn ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL read_rd_cnt: got %0d want %0d", rd_cnt, StatsEn ? 1 : 0);
    end
  endtask

  task automatic test_empty_read();
    int re0, seen;
    re0 = re_cnt; seen = 0;
    bus.fifo_avail = '0;
    #1 bus.rd_req = 1'b1;
    @(posedge clk); #1 bus.rd_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.rd_empty) seen++;
    end
    n_checks++;
    if (seen !== 1) begin
      n_fail++; $display("FAIL empty_pulse: rd_empty cycles got %0d want 1 within 2 cycles", seen);
    end
    repeat (6) @(posedge clk);
    n_checks++;
    if (re_cnt - re0 !== 0 || bus.rd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_no_re: re/pending got %0d/%b want 0/0", re_cnt - re0, bus.rd_pending);
    end
  endtask

  task automatic test_write_read();
    int both0;
    bit found;
    both0 = both_cnt; found = 0;
    bus.fifo_avail = '0; model_rdata = 32'h33334444;
    #1; bus.wr_valid = 1'b1; bus.wr_data = 32'h11112222; bus.rd_req = 1'b1;
    @(posedge clk); #1; bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fifo_we) found = 1;
    end
    n_checks++;
    if (!found || bus.fifo_re !== 1'b1 || bus.fifo_din !== 32'h11112222) begin
      n_fail++;
      $display("FAIL combined_issue: we/re/din got %b/%b/%h want 1/1/11112222",
               found, bus.fifo_re, bus.fifo_din);
    end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.rd_valid) found = 1;
    end
    n_checks++;
    if (!found || bus.rd_data !== 32'h33334444) begin
      n_fail++; $display("FAIL combined_data: valid/data got %b/%h want 1/33334444", found, bus.rd_data);
    end
    repeat (10) @(posedge clk);
    n_checks++;
    if (both_cnt - both0 !== 1) begin
      n_fail++; $display("FAIL combined_count: joint pulses got %0d want 1", both_cnt - both0);
    end
  endtask

  task automatic test_full_drain();
    int we0;
    logic exp_rdy;
    logic [31:0] exp_din;
    we0 = we_cnt;
    din_q.delete();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.wr_valid = 1'b1; bus.wr_data = 32'hA5A50000 + 32'(i);
      @(negedge clk);
      exp_rdy = (i < 4);
      n_checks++;
      if (bus.wr_ready !== exp_rdy) begin
        n_fail++; $display("FAIL full_wr_ready_%0d: got %b want %b", i, bus.wr_ready, exp_rdy);
      end
    end
    @(posedge clk); #1 bus.wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    n_checks++;
    if (we_cnt - we0 !== 0) begin
      n_fail++; $display("FAIL full_no_write: fifo_we pulses got %0d want 0", we_cnt - we0);
    end
    #1 bus.fifo_full = 1'b0;
    repeat (50) @(posedge clk);
    n_checks++;
    if (we_cnt - we0 !== 4) begin
      n_fail++; $display("FAIL drain_count: fifo_we pulses got %0d want 4", we_cnt - we0);
    end
    for (int i = 0; i < 4; i++) begin
      exp_din = 32'hA5A50000 + 32'(i);
      n_checks++;
      if (din_q.size() <= i || din_q[i] !== exp_din) begin
        n_fail++;
        $display("FAIL drain_order_%0d: got %h want %h", i,
                 (din_q.size() > i) ? din_q[i] : 32'hx, exp_din);
      end
    end
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_wr_ready: got %b want 1", bus.wr_ready);
    end
  endtask

  task automatic test_busy_timeout();
    bit found, early;
    found = 0; early = 0;
    model_on = 1'b0;
    #1; bus.wr_valid = 1'b1; bus.wr_data = 32'h0BADF00D;
    @(posedge clk); #1 bus.wr_valid = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fifo_we) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL tmo_issue: fifo_we seen got 0 want 1");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (err) early = 1;
    end
    n_checks++;
    if (early) begin
      n_fail++; $display("FAIL tmo_early: err during wait got 1 want 0");
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_err: got %b want 1 after 4 cycles", err);
    end
    model_on = 1'b1;
    @(posedge clk); #1; bus.wr_valid = 1'b1; bus.wr_data = 32'h600DCAFE;
    @(posedge clk); #1 bus.wr_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fifo_we) found = 1;
    end
    n_checks++;
    if (!found || bus.fifo_din !== 32'h600DCAFE) begin
      n_fail++; $display("FAIL tmo_recover: we/din got %b/%h want 1/600dcafe", found, bus.fifo_din);
    end
    repeat (12) @(posedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_sticky: err got %b want 1", err);
    end
    n_checks++;
    if (wr_cnt !== (StatsEn ? 32'd8 : 32'd0)) begin
      n_fail++; $display("FAIL tmo_wr_cnt: got %0d want %0d", wr_cnt, StatsEn ? 8 : 0);
    end
  endtask

  task automatic test_reset_mid();
    int rv0, re0;
    bit found;
    rv0 = rv_cnt; re0 = re_cnt; found = 0;
    bus.fifo_avail = 22'd3; model_rdata = 32'hCAFEBABE;
    #1 bus.rd_req = 1'b1;
    @(posedge clk); #1 bus.rd_req = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fifo_busy) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rstmid_busy: busy seen got 0 want 1");
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_wr_ready: got %b want 1", bus.wr_ready);
    end
    n_checks++;
    if ({bus.rd_valid, bus.rd_empty, bus.rd_pending, bus.fifo_we, bus.fifo_re, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_flags: got %b want 000000",
               {bus.rd_valid, bus.rd_empty, bus.rd_pending, bus.fifo_we, bus.fifo_re, err});
    end
    n_checks++;
    if ({bus.rd_data, bus.fifo_din, wr_cnt, rd_cnt} !== 128'b0) begin
      n_fail++; $display("FAIL rstmid_words: got %h want 0", {bus.rd_data, bus.fifo_din, wr_cnt, rd_cnt});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    n_checks++;
    if (rv_cnt - rv0 !== 0 || re_cnt - re0 !== 1 || bus.rd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: valid/re/pending got %0d/%0d/%b want 0/1/0",
               rv_cnt - rv0, re_cnt - re0, bus.rd_pending);
    end
    n_checks++;
    if (pulse_viol !== 0) begin
      n_fail++; $display("FAIL pulse_width: multi-cycle command pulses got %0d want 0", pulse_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_empty_read();
    test_write_read();
    test_full_drain();
    test_busy_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
